sr_cmd_conditioner: RTL
=======================

Name: sr_cmd_conditioner

Overview:
Upstream stage for the positive-edge SR flip-flop: converts two raw, asynchronous, bouncy request lines (set button, clear button) into clean, mutually exclusive, fixed-width s/r command pulses. Each input is synchronised, debounced and rising-edge detected, then a small FSM arbitrates simultaneous requests. The FSM guarantees s and r are never both 1, so the flip-flop never sees its invalid 2'b11 code. Outputs s and r connect directly to the flip-flop's s and r inputs on the same clk.

Parameters:
SYNC_STAGES, 2, synchroniser depth per raw input (legal: >=2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a level change (legal: >=1)
PULSE_LEN, 1, width of each s/r command pulse in clk cycles (legal: >=1)
SET_PRIORITY, 0, arbitration on simultaneous events: 1 = set wins, 0 = clear wins
CNT_W, 8, width of conflict counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
set_btn  in  1  raw set request, asynchronous to clk, may bounce
clr_btn  in  1  raw clear request, asynchronous to clk, may bounce
enable  in  1  synchronous; when 0, new events are ignored in IDLE
s  out  1  set command to flip-flop, registered
r  out  1  reset command to flip-flop, registered
busy  out  1  high in PULSE and HOLD states
conflict_cnt  out  CNT_W  saturating count of simultaneous-event arbitrations

Behaviour:
- Reset (rst_n=0, asynchronous): s=0, r=0, busy=0, conflict_cnt=0. Sync flops, debounced levels, counters and edge-detect history all clear to 0. FSM goes to IDLE. Asserting reset mid-pulse drops s/r immediately.
- Sync: each raw input passes through SYNC_STAGES flops. Raw inputs have no other use.
- Debounce, per input:
  - Counter increments while synced != debounced level.
  - Counter clears to 0 on any cycle where synced == debounced level.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the debounced level.
- Edge detect: set_evt / clr_evt = debounced level rising (debounced level 1, previous cycle's value 0). Both are one cycle wide.
- FSM states: IDLE, PULSE, HOLD.
  - IDLE: if enable=1 and either event is present, register the command and go to PULSE.
    - Only set_evt: s=1.
    - Only clr_evt: r=1.
    - Both in the same cycle: the SET_PRIORITY winner is issued, and conflict_cnt increments, saturating at all-ones.
    - If enable=0, events are discarded, not queued.
  - PULSE: hold the chosen output for exactly PULSE_LEN cycles, then deassert both and go to HOLD. enable is ignored here, and a started pulse always completes.
  - HOLD: wait until both debounced levels are 0, then go to IDLE. This requires a release before re-arm, so a held button produces exactly one pulse.
  - Events arriving in PULSE or HOLD are dropped.
- Invariant: s & r == 0 on every cycle, including reset exit.
- Latency: with raw input held stable, s/r rises exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk rising edges after the first edge that samples the new raw level. With defaults this is 19.
- Edge cases:
  - With PULSE_LEN=1, back-to-back commands are separated by at least one HOLD cycle.
  - Reset release with a button already held: after debounce, one event fires, which is the intended power-on behaviour.

Decomposition:
- Package sr_cmd_pkg holds:
  - the state enum (IDLE, PULSE, HOLD)
  - the priority constants PRIO_CLR=0 and PRIO_SET=1
  - a pulse-length counter width function (clog2-based)
- One sub-module, sync_debounce, is natural: parameterised SYNC_STAGES/DEBOUNCE_CYCLES, ports clk, rst_n, din, level. It is instantiated twice, once for set and once for clear.
- Edge detect and FSM stay in the top level.

Test Plan:
- Defaults: set_btn 0->1 held 40 cycles -> s=1 for exactly 1 cycle at edge 19, r stays 0, busy high until set_btn released and debounced.
- set_btn bounces (1 for 5 cycles, 0 for 3, 1 for 7), then held stable -> no pulse during bounce; exactly one s pulse 19 cycles after the final stable rise.
- set_btn and clr_btn rise on the same edge, SET_PRIORITY=0 -> r pulses once, s never 1, conflict_cnt 0->1. Repeat with SET_PRIORITY=1 -> s pulses instead.
- clr_btn held, then set_btn pressed while in HOLD -> no s pulse. After both released, a fresh set_btn press -> s pulse.
- PULSE_LEN=4, rst_n asserted 2 cycles into an s pulse -> s=0 asynchronously, busy=0, conflict_cnt=0. After release, no spurious pulse while inputs are 0.
- enable=0 during a clean set_btn press -> no pulse. enable raised mid-PULSE of a later press -> pulse completes unchanged. Assertion checks s&r==0 throughout all tests.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared state encoding, priority constants and sizing helper for the SR command conditioner.
package sr_cmd_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    localparam bit PRIO_CLR = 1'b0;
    localparam bit PRIO_SET = 1'b1;

    function automatic int pulse_cnt_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/sr_cmd_conditioner_sync_debounce.sv
// sync_debounce: synchronises one raw asynchronous input and accepts a level change only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement with the current debounced level.
module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign level  = level_q;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        level_d = (synced != level_q && cnt_q == LAST) ? synced : level_q;
        cnt_d   = (synced == level_q || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: turns bouncy set/clear buttons into mutually exclusive, fixed-width s/r pulses
// for a downstream SR flip-flop; simultaneous presses are arbitrated and counted.
module sr_cmd_conditioner
    import sr_cmd_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_LEN       = 1,
    parameter bit SET_PRIORITY    = PRIO_CLR,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_btn,
    input  logic             clr_btn,
    input  logic             enable,
    output logic             s,
    output logic             r,
    output logic             busy,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int PW = pulse_cnt_w(PULSE_LEN);

    logic             set_lvl, clr_lvl, set_evt, clr_evt, win_set;
    logic             set_prev_q, clr_prev_q;
    state_t           state_q, state_d;
    logic             s_q, s_d, r_q, r_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
        .clk(clk), .rst_n(rst_n), .din(set_btn), .level(set_lvl)
    );
    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk(clk), .rst_n(rst_n), .din(clr_btn), .level(clr_lvl)
    );

    assign set_evt = set_lvl & ~set_prev_q;
    assign clr_evt = clr_lvl & ~clr_prev_q;
    assign win_set = set_evt & (~clr_evt | (SET_PRIORITY == PRIO_SET));

    // s_d and r_d are only ever loaded as complements or both cleared, so s & r stays 0.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        r_d     = r_q;
        pcnt_d  = pcnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (enable && (set_evt || clr_evt)) begin
                state_d = PULSE;
                s_d     = win_set;
                r_d     = ~win_set;
                pcnt_d  = '0;
                cnt_d   = (set_evt && clr_evt && ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
            end
            PULSE: if (pcnt_q == PW'(PULSE_LEN - 1)) begin
                state_d = HOLD;
                s_d     = 1'b0;
                r_d     = 1'b0;
            end else begin
                pcnt_d = pcnt_q + PW'(1);
            end
            HOLD: state_d = (!set_lvl && !clr_lvl) ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            pcnt_q     <= '0;
            cnt_q      <= '0;
            set_prev_q <= 1'b0;
            clr_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            r_q        <= r_d;
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            set_prev_q <= set_lvl;
            clr_prev_q <= clr_lvl;
        end
    end

    assign s            = s_q;
    assign r            = r_q;
    assign busy         = (state_q != IDLE);
    assign conflict_cnt = cnt_q;

endmodule
